// File: rtl/hit_write_arbiter_if.sv
// Shared write-port bundle: requester handshakes on one side, the single memory
// write port on the other. The slave modport is the arbiter's view.
interface hit_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      waitrequest;
  logic                      write_enable;
  logic [ADDR_W-1:0]         addr_out;
  logic [DATA_W-1:0]         data_out;

  modport slave (
    input  req_valid, req_last, req_data, waitrequest,
    output req_ack, write_enable, addr_out, data_out
  );

  modport master (
    output req_valid, req_last, req_data, waitrequest,
    input  req_ack, write_enable, addr_out, data_out
  );
endinterface

// File: rtl/hit_write_arbiter.sv
// Round-robin arbiter sharing one memory write port among NUM_REQ hit-capture units;
// each unit owns a ring region whose write pointer and sticky wrap flag live here.
module hit_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REGION_WORDS = 256,
  parameter int BASE_ADDR    = 0,
  parameter int MAX_BURST    = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  hit_write_arbiter_if.slave bus,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] wrapped
);
  localparam int                PTR_W        = $clog2(REGION_WORDS);
  localparam int                CNT_W        = $clog2(MAX_BURST + 1);
  localparam logic [2:0]        RR_INIT      = 3'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] REGION_BYTES = ADDR_W'(REGION_WORDS * 4);
  localparam logic [CNT_W-1:0]  BEAT_LAST    = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [2:0]         grant_r, grant_nxt_s;
  logic [2:0]         rr_last_r, rr_last_nxt_s;
  logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_nxt_s;
  logic [PTR_W-1:0]   wptr_r [NUM_REQ];
  logic [NUM_REQ-1:0] wrapped_r;

  logic               pick_found_s;
  logic [2:0]         pick_id_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [PTR_W-1:0]   sel_ptr_s;
  logic               accept_s;

  assign grant_id = grant_r;
  assign wrapped  = wrapped_r;

  // Rotating-priority pick: first valid requester after the last owner
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = 3'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pick_found_s && bus.req_valid[k] && (k == (int'(rr_last_r) + i) % NUM_REQ)) begin
          pick_found_s = 1'b1;
          pick_id_s    = 3'(k);
        end else begin
          pick_found_s = pick_found_s;
        end
      end
    end
  end

  // AND-OR mux of the current owner's request and write pointer
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    sel_ptr_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_valid_s = sel_valid_s | (bus.req_valid[k] & (grant_r == 3'(k)));
      sel_last_s  = sel_last_s  | (bus.req_last[k]  & (grant_r == 3'(k)));
      sel_data_s  = sel_data_s  | ({DATA_W{grant_r == 3'(k)}} & bus.req_data[k*DATA_W +: DATA_W]);
      sel_ptr_s   = sel_ptr_s   | ({PTR_W{grant_r == 3'(k)}} & wptr_r[k]);
    end
  end

  // FSM next state and write-port outputs
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    rr_last_nxt_s    = rr_last_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    accept_s         = 1'b0;
    busy             = 1'b0;
    bus.write_enable = 1'b0;
    bus.req_ack      = '0;
    bus.addr_out     = '0;
    bus.data_out     = '0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s    = ST_BURST;
          grant_nxt_s    = pick_id_s;
          beat_cnt_nxt_s = '0;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_BURST: begin
        busy             = 1'b1;
        bus.write_enable = sel_valid_s;
        bus.data_out     = sel_data_s;
        bus.addr_out     = ADDR_W'(BASE_ADDR) + ADDR_W'(grant_r) * REGION_BYTES
                         + (ADDR_W'(sel_ptr_s) << 2);
        // a clearing cycle never consumes the presented word
        accept_s = sel_valid_s & ~bus.waitrequest & ~clear;
        for (int k = 0; k < NUM_REQ; k++) begin
          bus.req_ack[k] = accept_s & (grant_r == 3'(k));
        end
        if (accept_s) begin
          beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
          if (sel_last_s || (beat_cnt_r == BEAT_LAST)) begin
            state_nxt_s   = ST_IDLE;
            rr_last_nxt_s = grant_r;
          end else begin
            state_nxt_s   = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM and arbitration state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= 3'd0;
      rr_last_r  <= RR_INIT;
      beat_cnt_r <= '0;
    end else if (clear) begin
      state_r    <= ST_IDLE;
      grant_r    <= 3'd0;
      rr_last_r  <= RR_INIT;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      rr_last_r  <= rr_last_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

  // Ring write pointers advance per accepted beat; wrap flag sticks until clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wptr_r[k] <= '0;
      end
      wrapped_r <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wptr_r[k] <= '0;
      end
      wrapped_r <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (accept_s && (grant_r == 3'(k))) begin
          wptr_r[k] <= wptr_r[k] + PTR_W'(1);
          if (wptr_r[k] == {PTR_W{1'b1}}) begin
            wrapped_r[k] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hit_write_arbiter.sv
// Bench for hit_write_arbiter: a requester driver feeds per-port word queues and a
// monitor checks every accepted write against a per-port expected-address scoreboard.
module tb_hit_write_arbiter;
  localparam int NR = 4;

  typedef struct {logic [31:0] data; logic last;} word_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} exp_t;
  typedef struct {int k; int len; logic [31:0] d0; logic [31:0] first_addr; logic [31:0] last_addr;} row_t;

  logic clk = 1'b0;
  logic n_rst;
  logic clear;
  logic [2:0] grant_id;
  logic busy;
  logic [NR-1:0] wrapped;

  hit_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(32), .ADDR_W(32)) bus ();

  hit_write_arbiter #(
    .NUM_REQ(NR), .DATA_W(32), .ADDR_W(32), .REGION_WORDS(256), .BASE_ADDR(0), .MAX_BURST(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus),
    .grant_id(grant_id), .busy(busy), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  word_t str_q [NR][$];
  exp_t exp_q [NR][$];
  int mptr [NR];
  int grant_log [$];
  int cyc_log [$];
  logic [31:0] addr_log [$];
  row_t rows [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic push_rec(input int k, input int len, input logic [31:0] d0);
    word_t w;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      w.data = d0 + 32'(i);
      w.last = (i == len - 1);
      e.addr = 32'(k) * 32'h400 + 32'(mptr[k]) * 32'd4;
      e.data = w.data;
      str_q[k].push_back(w);
      exp_q[k].push_back(e);
      mptr[k] = (mptr[k] + 1) % 256;
    end
  endtask

  task automatic flush_all();
    for (int k = 0; k < NR; k++) begin
      str_q[k].delete();
      exp_q[k].delete();
      mptr[k] = 0;
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int k = 0; k < NR; k++) begin
      if (str_q[k].size() != 0 || exp_q[k].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk); #1;
      done = queues_empty() && !busy;
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input int cnt, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk); #1;
      done = (addr_log.size() >= cnt);
    end
    chk("beat_timeout", 32'(done), 32'd1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int k = 0; k < NR; k++) mptr[k] = 0;
  endtask

  // requester model: presents the head of each port's queue, redrawn after every edge
  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge clk); #2;
      for (int k = 0; k < NR; k++) begin
        if (str_q[k].size() > 0) begin
          bus.req_valid[k]         = 1'b1;
          bus.req_last[k]          = str_q[k][0].last;
          bus.req_data[k*32 +: 32] = str_q[k][0].data;
        end else begin
          bus.req_valid[k]         = 1'b0;
          bus.req_last[k]          = 1'b0;
          bus.req_data[k*32 +: 32] = 32'h0;
        end
      end
    end
  end

  // write monitor: every acknowledged word must be the next one owed to that port
  always begin
    exp_t e;
    @(negedge clk);
    if (n_rst && !clear) begin
      chk("we_without_ack", 32'(bus.write_enable && !bus.waitrequest && (bus.req_ack == 4'b0)), 32'd0);
      for (int k = 0; k < NR; k++) begin
        if (bus.req_ack[k]) begin
          chk("ack_owner", 32'(grant_id), 32'(k));
          chk("ack_we", 32'(bus.write_enable), 32'd1);
          chk("sb_pending", 32'(exp_q[k].size() > 0), 32'd1);
          if (exp_q[k].size() > 0) begin
            e = exp_q[k].pop_front();
            chk("sb_addr", bus.addr_out, e.addr);
            chk("sb_data", bus.data_out, e.data);
          end
          if (str_q[k].size() > 0) void'(str_q[k].pop_front());
          grant_log.push_back(k);
          cyc_log.push_back(cyc);
          addr_log.push_back(bus.addr_out);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{1, 3, 32'hA1, 32'h400, 32'h408};
    rows[1] = '{1, 1, 32'hB0, 32'h40C, 32'h40C};
    rows[2] = '{0, 2, 32'hC0, 32'h004, 32'h008};
    rows[3] = '{2, 1, 32'hD0, 32'h800, 32'h800};
    rows[4] = '{3, 4, 32'hE0, 32'hC00, 32'hC0C};
    rows[5] = '{2, 2, 32'hF0, 32'h804, 32'h808};
    for (int k = 0; k < NR; k++) mptr[k] = 0;
    n_rst = 1'b0;
    clear = 1'b0;
    bus.waitrequest = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_we", 32'(bus.write_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_addr", bus.addr_out, 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_ack", 32'(bus.req_ack), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // reset in the middle of a burst
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(0, 5, 32'h100);
    wait_beats(2, 50);
    @(posedge clk); #1;
    n_rst = 1'b0;
    flush_all();
    @(negedge clk); #1;
    chk("midrst_we", 32'(bus.write_enable), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wrapped", 32'(wrapped), 32'd0);
    chk("midrst_ack", 32'(bus.req_ack), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(0, 1, 32'h1F0);
    wait_idle(50);
    chk("midrst_next_addr", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'h000);

    // single records from idle: latency, start address and pointer continuity
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      addr_log.delete();
      push_rec(rows[r].k, rows[r].len, rows[r].d0);
      @(negedge clk); #1;
      chk("tbl_idle_we", 32'(bus.write_enable), 32'd0);
      chk("tbl_idle_busy", 32'(busy), 32'd0);
      @(negedge clk); #1;
      chk("tbl_lat_we", 32'(bus.write_enable), 32'd1);
      chk("tbl_lat_grant", 32'(grant_id), 32'(rows[r].k));
      chk("tbl_first_addr", bus.addr_out, rows[r].first_addr);
      wait_idle(100);
      chk("tbl_beats", 32'(addr_log.size()), 32'(rows[r].len));
      chk("tbl_last_addr", addr_log.size() > 0 ? addr_log[addr_log.size()-1] : 32'hFFFF_FFFF, rows[r].last_addr);
    end

    // all four requesters with 1-word records: strict rotation, one write per 2 cycles
    pulse_clear();
    @(posedge clk); #1;
    grant_log.delete();
    cyc_log.delete();
    addr_log.delete();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NR; k++) push_rec(k, 1, 32'h300 + 32'(r * 16 + k));
    wait_idle(200);
    chk("rr_count", 32'(grant_log.size()), 32'd12);
    for (int i = 0; i < grant_log.size() && i < 12; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 4));
    for (int i = 1; i < cyc_log.size() && i < 12; i++) chk("rr_cadence", 32'(cyc_log[i] - cyc_log[i-1]), 32'd2);

    // waitrequest stall mid-burst of requester 2 (pointer at 3 -> 0x80C)
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(2, 6, 32'h400);
    wait_beats(2, 50);
    @(posedge clk); #1;
    bus.waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall_addr", bus.addr_out, 32'h814);
      chk("stall_data", bus.data_out, 32'h402);
      chk("stall_we", 32'(bus.write_enable), 32'd1);
      chk("stall_ack", 32'(bus.req_ack), 32'd0);
    end
    @(posedge clk); #1;
    bus.waitrequest = 1'b0;
    wait_idle(50);
    chk("stall_beats", 32'(addr_log.size()), 32'd6);
    chk("stall_end_addr", addr_log.size() == 6 ? addr_log[5] : 32'hFFFF_FFFF, 32'h820);

    // 40-word stream on 0 is cut at 16 beats so pending requester 3 gets in
    @(posedge clk); #1;
    grant_log.delete();
    addr_log.delete();
    push_rec(0, 40, 32'h1000);
    @(posedge clk); #1;
    push_rec(3, 3, 32'h3000);
    wait_idle(300);
    chk("burst_count", 32'(grant_log.size()), 32'd43);
    for (int i = 0; i < grant_log.size() && i < 43; i++)
      chk("burst_order", 32'(grant_log[i]), (i >= 16 && i < 19) ? 32'd3 : 32'd0);
    chk("burst_req3_addr", addr_log.size() > 16 ? addr_log[16] : 32'hFFFF_FFFF, 32'hC0C);
    chk("burst_resume_addr", addr_log.size() > 19 ? addr_log[19] : 32'hFFFF_FFFF, 32'h04C);

    // ring wrap of requester 3, then clear
    pulse_clear();
    @(negedge clk); #1;
    chk("clr_wrapped_pre", 32'(wrapped), 32'd0);
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(3, 257, 32'h5000);
    wait_beats(256, 400);
    chk("wrap_before", 32'(wrapped), 32'd0);
    @(negedge clk); #1;
    chk("wrap_set", 32'(wrapped), 32'h8);
    wait_idle(100);
    chk("wrap_beats", 32'(addr_log.size()), 32'd257);
    chk("wrap_top_addr", addr_log.size() == 257 ? addr_log[255] : 32'hFFFF_FFFF, 32'hFFC);
    chk("wrap_257_addr", addr_log.size() == 257 ? addr_log[256] : 32'hFFFF_FFFF, 32'hC00);
    pulse_clear();
    @(negedge clk); #1;
    chk("clr_wrapped", 32'(wrapped), 32'd0);
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(3, 1, 32'h6000);
    wait_idle(50);
    chk("clr_next_addr", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'hC00);

    // clear in the middle of a burst drops the presented word and the grant
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(1, 5, 32'h7000);
    wait_beats(2, 50);
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk); #1;
    chk("midclr_ack", 32'(bus.req_ack), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    flush_all();
    @(negedge clk); #1;
    chk("midclr_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    addr_log.delete();
    push_rec(1, 2, 32'h7100);
    wait_idle(50);
    chk("midclr_next_addr", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'h400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
